pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Parametrised pipeline control unit for the RV32 core; successor to the single-cycle jump/hold controller.
- Arbitrates redirect requests: branch/jump from EX, and interrupt entry from the CSR/interrupt unit.
- Merges per-stage hold requests into per-stage stall vectors and defers redirects while the pipe is held.
- Issues registered, single-pulse PC redirects followed by a multi-cycle flush window. Sits between ex/clint and pc_reg/if_id/id_ex.

Parameters:
- ADDR_W, 32, width of redirect addresses.
- NUM_STAGES, 4, number of pipeline stages controlled; stage 0 = IF.
- FLUSH_MASK, 4'b0111, per-stage flush enable; bit k set means stage k is flushed on redirect.
- FLUSH_CYCLES, 2, cycles flush_o stays asserted after issue; legal range 1..15.
- RESET_ADDR, 32'h0, value of jump_addr_o after reset.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- jump_en_i  in  1  EX branch/jump taken
- jump_addr_i  in  ADDR_W  EX target
- irq_req_i  in  1  interrupt entry request, level, held until irq_ack_o
- irq_addr_i  in  ADDR_W  trap vector
- hold_req_i  in  NUM_STAGES  bit k: stage k cannot advance
- jump_en_o  out  1  one-cycle redirect pulse to pc_reg
- jump_addr_o  out  ADDR_W  redirect target, held stable between pulses
- irq_ack_o  out  1  one-cycle pulse, same cycle as the jump_en_o issuing the irq
- hold_o  out  NUM_STAGES  per-stage stall
- flush_o  out  NUM_STAGES  per-stage flush
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, jump_en_o=0, irq_ack_o=0, flush_o=0, cnt=0, pend_irq=0, jump_addr_o=RESET_ADDR. Pending request is discarded.
- hold_o is combinational: hold_o[j] = OR of hold_req_i[k] for k>=j. A stalled later stage stalls all earlier stages. hold_o is independent of state.
- any_hold = |hold_req_i.
- Request select: irq_req_i has priority over jump_en_i. When both are present in the same cycle, the jump is dropped.
- States: IDLE, PEND, FLUSH.
- IDLE, with a request and !any_hold:
  - Next cycle: jump_en_o=1, jump_addr_o=selected address, irq_ack_o=1 if the request was an irq.
  - flush_o=FLUSH_MASK, cnt=FLUSH_CYCLES-1, go to FLUSH.
  - Latency from request to jump_en_o is exactly 1 cycle.
- IDLE, with a request and any_hold:
  - Latch the address and the irq flag into the pending register, go to PEND.
- PEND:
  - The pending request is issued the first cycle any_hold=0: same outputs on the next cycle as the IDLE issue, then go to FLUSH.
  - jump_en_i while in PEND is ignored.
  - irq_req_i while in PEND with a pending jump replaces it (address overwritten, irq flag set).
  - irq_req_i while in PEND with a pending irq is a no-op.
- FLUSH:
  - jump_en_o and irq_ack_o are high only in the first FLUSH cycle.
  - flush_o=FLUSH_MASK for FLUSH_CYCLES consecutive cycles.
  - cnt decrements each cycle. When cnt==0 at the clock edge, flush_o drops and the state returns to IDLE.
  - jump_en_i during FLUSH is ignored (wrong-path).
  - irq_req_i during FLUSH that is not yet acknowledged is evaluated in IDLE after the window. It is a level signal and is not latched.
  - hold_req_i does not extend or pause the flush window.
- No request in IDLE: all registered outputs are 0. jump_addr_o retains its last value.
- Back-to-back: the earliest second issue is FLUSH_CYCLES+1 cycles after the first jump_en_o.
- Reset mid-PEND or mid-FLUSH returns immediately to IDLE with reset values, and no pulse is emitted.

Test Plan:
- Basic jump: reset, then jump_en_i=1, addr=0x100, for 1 cycle with hold=0 -> next cycle jump_en_o=1, addr_o=0x100, flush_o=4'b0111 for 2 cycles, busy_o high 2 cycles, then IDLE.
- Hold deferral: hold_req_i=4'b0100 for 3 cycles while jump_en_i pulses addr=0x200 in the first of them -> hold_o=4'b0111 during the hold; jump_en_o fires exactly 1 cycle after hold clears, addr 0x200.
- Priority: jump_en_i (0x300) and irq_req_i (vector 0x80) in the same cycle -> jump_en_o with addr 0x80 and irq_ack_o=1 together; 0x300 is never issued.
- Irq overrides pending: jump 0x400 arrives under hold, then irq 0x80 arrives while still in PEND -> a single issue to 0x80 with irq_ack_o=1.
- Flush window: jump_en_i arrives in the second FLUSH cycle -> ignored. Held irq_req_i during FLUSH -> issued 1 cycle after FLUSH ends. With FLUSH_CYCLES=3, flush_o stays high exactly 3 cycles.
- Async reset: assert rst=0 mid-PEND, between clock edges -> all outputs reset immediately, jump_addr_o=RESET_ADDR; no jump_en_o after release without a new request.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: arbitrates EX redirects and interrupt entry, merges stage
// holds into stall vectors, and issues a registered redirect pulse plus flush window.
module pipe_ctrl #(
   parameter int                    ADDR_W       = 32,
   parameter int                    NUM_STAGES   = 4,
   parameter logic [NUM_STAGES-1:0] FLUSH_MASK   = 4'b0111,
   parameter int                    FLUSH_CYCLES = 2,
   parameter logic [ADDR_W-1:0]     RESET_ADDR   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  jump_en_i,
   input  logic [ADDR_W-1:0]     jump_addr_i,
   input  logic                  irq_req_i,
   input  logic [ADDR_W-1:0]     irq_addr_i,
   input  logic [NUM_STAGES-1:0] hold_req_i,
   output logic                  jump_en_o,
   output logic [ADDR_W-1:0]     jump_addr_o,
   output logic                  irq_ack_o,
   output logic [NUM_STAGES-1:0] hold_o,
   output logic [NUM_STAGES-1:0] flush_o,
   output logic                  busy_o
);

   // state | meaning
   // IDLE  | no redirect in progress; requests are issued or deferred
   // PEND  | request latched while the pipe is held; waits for hold release
   // FLUSH | redirect issued; flush window counting down
   typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

   localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
   logic                pend_irq_q, pend_irq_d;
   logic [ADDR_W-1:0]   jump_addr_q, jump_addr_d;
   logic                jump_en_q, jump_en_d;
   logic                irq_ack_q, irq_ack_d;
   logic [NUM_STAGES-1:0] flush_q, flush_d;

   logic                any_hold;
   logic                req;
   logic [ADDR_W-1:0]   req_addr;
   logic                issue;
   logic [ADDR_W-1:0]   issue_addr;
   logic                issue_irq;

   // A stalled later stage must stall every earlier stage.
   always_comb begin
      logic acc;
      acc    = 1'b0;
      hold_o = '0;
      for (int j = NUM_STAGES - 1; j >= 0; j--) begin
         acc       = acc | hold_req_i[j];
         hold_o[j] = acc;
      end
   end

   assign any_hold = |hold_req_i;
   assign req      = irq_req_i | jump_en_i;
   assign req_addr = irq_req_i ? irq_addr_i : jump_addr_i;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_addr_d = pend_addr_q;
      pend_irq_d  = pend_irq_q;
      jump_addr_d = jump_addr_q;
      jump_en_d   = 1'b0;
      irq_ack_d   = 1'b0;
      flush_d     = '0;
      issue       = 1'b0;
      issue_addr  = req_addr;
      issue_irq   = irq_req_i;

      case (state_q)
         IDLE: begin
            if (req) begin
               if (!any_hold) begin
                  issue = 1'b1;
               end else begin
                  pend_addr_d = req_addr;
                  pend_irq_d  = irq_req_i;
                  state_d     = PEND;
               end
            end
         end
         PEND: begin
            // An interrupt supersedes a deferred jump; new jumps are ignored here.
            if (irq_req_i && !pend_irq_q) begin
               issue_addr = irq_addr_i;
               issue_irq  = 1'b1;
            end else begin
               issue_addr = pend_addr_q;
               issue_irq  = pend_irq_q;
            end
            if (!any_hold) begin
               issue = 1'b1;
            end else begin
               pend_addr_d = issue_addr;
               pend_irq_d  = issue_irq;
            end
         end
         FLUSH: begin
            if (cnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d   = cnt_q - 4'd1;
               flush_d = FLUSH_MASK;
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         jump_en_d   = 1'b1;
         jump_addr_d = issue_addr;
         irq_ack_d   = issue_irq;
         flush_d     = FLUSH_MASK;
         cnt_d       = CNT_INIT;
         pend_irq_d  = 1'b0;
         state_d     = FLUSH;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         pend_addr_q <= '0;
         pend_irq_q  <= 1'b0;
         jump_addr_q <= RESET_ADDR;
         jump_en_q   <= 1'b0;
         irq_ack_q   <= 1'b0;
         flush_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_addr_q <= pend_addr_d;
         pend_irq_q  <= pend_irq_d;
         jump_addr_q <= jump_addr_d;
         jump_en_q   <= jump_en_d;
         irq_ack_q   <= irq_ack_d;
         flush_q     <= flush_d;
      end
   end

   assign jump_en_o   = jump_en_q;
   assign jump_addr_o = jump_addr_q;
   assign irq_ack_o   = irq_ack_q;
   assign flush_o     = flush_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected redirects are queued at stimulus time
// and matched against each jump_en_o pulse; a second instance uses a 3-cycle flush.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        jump_en_i = 1'b0;
   logic [31:0] jump_addr_i = '0;
   logic        irq_req_i = 1'b0;
   logic [31:0] irq_addr_i = '0;
   logic [3:0]  hold_req_i = '0;

   logic        jump_en_o, irq_ack_o, busy_o;
   logic [31:0] jump_addr_o;
   logic [3:0]  hold_o, flush_o;

   logic        jump_en3, irq_ack3, busy3;
   logic [31:0] jump_addr3;
   logic [3:0]  hold3, flush3;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic        irq;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk(clk), .rst(rst),
      .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
      .irq_req_i(irq_req_i), .irq_addr_i(irq_addr_i),
      .hold_req_i(hold_req_i),
      .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o), .irq_ack_o(irq_ack_o),
      .hold_o(hold_o), .flush_o(flush_o), .busy_o(busy_o)
   );

   pipe_ctrl #(.FLUSH_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst),
      .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
      .irq_req_i(irq_req_i), .irq_addr_i(irq_addr_i),
      .hold_req_i(hold_req_i),
      .jump_en_o(jump_en3), .jump_addr_o(jump_addr3), .irq_ack_o(irq_ack3),
      .hold_o(hold3), .flush_o(flush3), .busy_o(busy3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] addr, input logic irq);
      exp_t e;
      e.addr = addr;
      e.irq  = irq;
      sb_q.push_back(e);
   endtask

   // Every redirect pulse must match the oldest expected redirect.
   always @(negedge clk) begin
      if (rst) begin
         if (irq_ack_o && !jump_en_o)
            chk("ack_without_jump", 1, 0);
         if (jump_en_o) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_jump", jump_addr_o, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("jump_addr", jump_addr_o, e.addr);
               chk("irq_ack", {31'b0, irq_ack_o}, {31'b0, e.irq});
            end
         end
      end
   end

   initial begin
      logic [3:0] pats[4];
      logic [3:0] exp_h;
      pats[0] = 4'b1000;
      pats[1] = 4'b0001;
      pats[2] = 4'b0010;
      pats[3] = 4'b0100;

      // reset values
      #2 rst = 1'b0;
      #1;
      chk("rst_jump_en", {31'b0, jump_en_o}, 0);
      chk("rst_jump_addr", jump_addr_o, 32'h0);
      chk("rst_irq_ack", {31'b0, irq_ack_o}, 0);
      chk("rst_flush", {28'b0, flush_o}, 0);
      chk("rst_busy", {31'b0, busy_o}, 0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // combinational stall merge
      foreach (pats[i]) begin
         hold_req_i = pats[i];
         exp_h = '0;
         for (int j = 0; j < 4; j++)
            exp_h[j] = |(pats[i] >> j);
         #1;
         chk("hold_o", {28'b0, hold_o}, {28'b0, exp_h});
      end
      hold_req_i = '0;
      tick();

      // basic jump, flush window of 2 (and 3 on dut3)
      jump_en_i = 1'b1; jump_addr_i = 32'h100;
      push_exp(32'h100, 1'b0);
      tick();
      jump_en_i = 1'b0;
      chk("b_jen1", {31'b0, jump_en_o}, 1);
      chk("b_flush1", {28'b0, flush_o}, 4'b0111);
      chk("b_busy1", {31'b0, busy_o}, 1);
      chk("b3_flush1", {28'b0, flush3}, 4'b0111);
      tick();
      chk("b_jen2", {31'b0, jump_en_o}, 0);
      chk("b_flush2", {28'b0, flush_o}, 4'b0111);
      chk("b_busy2", {31'b0, busy_o}, 1);
      chk("b3_flush2", {28'b0, flush3}, 4'b0111);
      tick();
      chk("b_flush3", {28'b0, flush_o}, 0);
      chk("b_busy3", {31'b0, busy_o}, 0);
      chk("b_addr_held", jump_addr_o, 32'h100);
      chk("b3_flush3", {28'b0, flush3}, 4'b0111);
      chk("b3_busy3", {31'b0, busy3}, 1);
      tick();
      chk("b3_flush4", {28'b0, flush3}, 0);
      chk("b3_busy4", {31'b0, busy3}, 0);
      tick();

      // hold deferral
      hold_req_i = 4'b0100;
      jump_en_i = 1'b1; jump_addr_i = 32'h200;
      push_exp(32'h200, 1'b0);
      #1;
      chk("h_hold_o", {28'b0, hold_o}, 4'b0111);
      tick();
      jump_en_i = 1'b0;
      chk("h_pend_busy", {31'b0, busy_o}, 1);
      chk("h_pend_jen", {31'b0, jump_en_o}, 0);
      tick();
      tick();
      hold_req_i = '0;
      chk("h_jen_before", {31'b0, jump_en_o}, 0);
      tick();
      chk("h_jen_after", {31'b0, jump_en_o}, 1);
      tick();
      tick();
      tick();

      // irq has priority over a simultaneous jump
      jump_en_i = 1'b1; jump_addr_i = 32'h300;
      irq_req_i = 1'b1; irq_addr_i = 32'h80;
      push_exp(32'h80, 1'b1);
      tick();
      jump_en_i = 1'b0; irq_req_i = 1'b0;
      chk("p_jen", {31'b0, jump_en_o}, 1);
      tick();
      tick();
      chk("p_idle", {31'b0, busy_o}, 0);
      tick();

      // irq overrides a pending jump
      hold_req_i = 4'b0001;
      jump_en_i = 1'b1; jump_addr_i = 32'h400;
      tick();
      jump_en_i = 1'b0;
      irq_req_i = 1'b1; irq_addr_i = 32'h84;
      tick();
      hold_req_i = '0;
      push_exp(32'h84, 1'b1);
      tick();
      irq_req_i = 1'b0;
      chk("o_ack", {31'b0, irq_ack_o}, 1);
      tick();
      tick();
      tick();

      // wrong-path jump during flush ignored; held irq issued right after window
      jump_en_i = 1'b1; jump_addr_i = 32'h500;
      push_exp(32'h500, 1'b0);
      tick();
      jump_en_i = 1'b0;
      tick();
      jump_en_i = 1'b1; jump_addr_i = 32'h600;
      irq_req_i = 1'b1; irq_addr_i = 32'h88;
      push_exp(32'h88, 1'b1);
      tick();
      jump_en_i = 1'b0;
      chk("f_idle_jen", {31'b0, jump_en_o}, 0);
      chk("f_idle_flush", {28'b0, flush_o}, 0);
      tick();
      irq_req_i = 1'b0;
      chk("f_b2b_jen", {31'b0, jump_en_o}, 1);
      chk("f_b2b_ack", {31'b0, irq_ack_o}, 1);
      tick();
      tick();
      tick();

      // async reset mid-PEND
      hold_req_i = 4'b0100;
      jump_en_i = 1'b1; jump_addr_i = 32'h700;
      tick();
      jump_en_i = 1'b0;
      chk("r_pend", {31'b0, busy_o}, 1);
      #2 rst = 1'b0;
      #1;
      chk("r_busy", {31'b0, busy_o}, 0);
      chk("r_addr", jump_addr_o, 32'h0);
      chk("r_flush", {28'b0, flush_o}, 0);
      chk("r_jen", {31'b0, jump_en_o}, 0);
      tick();
      hold_req_i = '0;
      rst = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      chk("r_after_busy", {31'b0, busy_o}, 0);
      chk("r_after_addr", jump_addr_o, 32'h0);

      chk("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
